ram_boot_loader: RTL and testbench
==================================

Name: ram_boot_loader

Overview:
Synthesizable program loader for the RISC_SPM memory. It clears data memory, streams a program image into consecutive RAM words, and holds the CPU in reset until loading is complete. This moves into hardware the clear, preload and reset-release sequence that the bench currently performs with direct memory writes. It sits between an external byte stream (UART/JTAG front-end) and the RAM write port, with its CPU-hold output gating the processor reset.

Parameters:
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W words
DATA_W, 8, RAM word width
CLR_VALUE, 0, word written to every location during the clear phase
CLR_ON_BOOT, 1, 1 = run the clear phase before loading; 0 = skip it
HOLD_CYCLES, 4, cycles the CPU stays held after the last program word is written (range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse that begins a boot sequence; sampled only in IDLE or DONE
base_addr  input  ADDR_W  first RAM address of the program image; sampled on start
in_valid  input  1  stream word valid
in_data  input  DATA_W  stream word
in_last  input  1  marks the final program word
in_ready  output  1  loader accepts the stream word this cycle
mem_we  output  1  RAM write enable (registered)
mem_addr  output  ADDR_W  RAM write address (registered)
mem_wdata  output  DATA_W  RAM write data (registered)
cpu_hold  output  1  active-high; drives CPU reset while 1
busy  output  1  FSM is not in IDLE or DONE
done  output  1  last boot completed without error
error  output  1  last boot overflowed (more than DEPTH words without in_last)

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, cpu_hold=1, busy=0, done=0, error=0. All counters are cleared.
- FSM states: IDLE, CLEAR, LOAD, HOLD, DONE.
- IDLE/DONE + start:
  - capture base_addr; done=0, error=0, cpu_hold=1, busy=1.
  - go to CLEAR if CLR_ON_BOOT=1, otherwise go to LOAD.
- start in any other state is ignored.
- CLEAR:
  - one write per cycle, address 0..DEPTH-1, data=CLR_VALUE; exactly DEPTH cycles with mem_we=1.
  - in_ready=0 throughout.
  - after address DEPTH-1 is issued, go to LOAD.
- LOAD:
  - in_ready=1.
  - a word is accepted on a cycle with in_valid & in_ready.
  - on the next cycle: mem_we=1, mem_addr=(base+count) mod DEPTH, mem_wdata=accepted word.
  - one-cycle latency; one word per cycle sustained; mem_we=0 on cycles with no accept.
  - count increments per accepted word; address wraps modulo DEPTH.
  - accept with in_last: in_ready drops the next cycle; go to HOLD.
  - accept without in_last where count becomes DEPTH: error=1; go to DONE with cpu_hold still 1 (CPU never released).
- HOLD:
  - in_ready=0; count HOLD_CYCLES cycles, then cpu_hold=0, done=1; go to DONE.
  - the final mem_we write is complete before cpu_hold falls.
- DONE: busy=0. Outputs hold until the next start or rst. A new start re-asserts cpu_hold in the cycle after it is sampled.
- Reset mid-operation: mem_we drops immediately (async); cpu_hold=1; no partial state survives.
- base_addr changes while busy have no effect.

Test Plan:
- CLR_ON_BOOT=1, DEPTH=256, CLR_VALUE=0, preload RAM with 0xFF, start, no stream words -> 256 consecutive mem_we cycles at addresses 0..255 with data 0x00, then in_ready=1, cpu_hold=1.
- base_addr=0, stream 0x00,0x50,0x82,0x54,0x83,0x14,0x61,0x82,0x73(last) -> RAM[0..8] holds the image; HOLD_CYCLES=4 after the last write, cpu_hold=0 and done=1; the CPU fetches NOP from address 0.
- CLR_ON_BOOT=0, base_addr=0xFE, stream 0xAA,0xBB,0xCC(last) -> writes go to 0xFE, 0xFF, 0x00 (wrap); no clear writes occur.
- in_valid toggling 1,0,1,0 during LOAD -> mem_we is 1 only in the cycle after each accept, and addresses are contiguous.
- Stream 256 words without in_last -> error=1, done=0, cpu_hold stays 1, busy=0; a second start clears error and reboots.
- rst pulse after 5 words in LOAD -> mem_we=0 and cpu_hold=1 within the reset pulse, state=IDLE; a new start restarts from CLEAR.
- start pulse during CLEAR -> ignored; the clear sequence finishes its 256 writes unchanged.

Source files
------------

// File: rtl/ram_boot_loader_if.sv
// Loader-side bundle: boot control, input word stream, RAM write port and CPU gating.
// The loader uses the slave modport; whoever drives the stream and start uses master.
interface ram_boot_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, base_addr, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );

  modport master (
    output start, base_addr, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/ram_boot_loader.sv
// Program loader: optionally clears RAM, streams an image from base_addr upward
// (wrapping), then releases the CPU hold a fixed number of cycles after the last write.
module ram_boot_loader #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLR_VALUE   = '0,
  parameter bit                CLR_ON_BOOT = 1'b1,
  parameter int unsigned       HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  ram_boot_loader_if.slave bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   base_q,      base_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [HOLD_W-1:0]   hold_q,      hold_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                in_ready_q,  in_ready_d;
  logic                cpu_hold_q,  cpu_hold_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                error_q,     error_d;
  logic                accept_c;

  assign accept_c = bus.in_valid & in_ready_q;

  // State and registered outputs; cpu_hold resets high so the CPU never runs unloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          base_d     = bus.base_addr;
          cnt_d      = '0;
          hold_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
          if (CLR_ON_BOOT) begin
            // First clear write is issued together with the state change.
            state_d     = S_CLEAR;
            mem_we_d    = 1'b1;
            mem_addr_d  = '0;
            mem_wdata_d = CLR_VALUE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_CLEAR: begin
        // mem_addr_q is the address currently being written.
        if (mem_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_LOAD;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_wdata_d = CLR_VALUE;
        end
      end

      S_LOAD: begin
        if (accept_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + cnt_q[ADDR_W-1:0];
          mem_wdata_d = bus.in_data;
          cnt_d       = cnt_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end else if (cnt_q == CNT_W'(DEPTH - 1)) begin
            // Image longer than RAM: abort with the CPU still held.
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d    = S_DONE;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_HOLD);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed bench for ram_boot_loader: one instance with clear enabled, one without.
module tb_ram_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_boot_loader_if #(.ADDR_W(8), .DATA_W(8)) bif_a ();
  ram_boot_loader_if #(.ADDR_W(8), .DATA_W(8)) bif_b ();

  ram_boot_loader #(.ADDR_W(8), .DATA_W(8), .CLR_VALUE(8'h00), .CLR_ON_BOOT(1'b1), .HOLD_CYCLES(4))
    dut_a (.clk(clk), .rst(rst), .bus(bif_a));
  ram_boot_loader #(.ADDR_W(8), .DATA_W(8), .CLR_VALUE(8'h00), .CLR_ON_BOOT(1'b0), .HOLD_CYCLES(1))
    dut_b (.clk(clk), .rst(rst), .bus(bif_b));

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  int wr_cnt_b = 0;

  always @(posedge clk) if (bif_a.mem_we) ram_a[bif_a.mem_addr] <= bif_a.mem_wdata;
  always @(posedge clk) if (bif_b.mem_we) begin
    ram_b[bif_b.mem_addr] <= bif_b.mem_wdata;
    wr_cnt_b <= wr_cnt_b + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       rdy;
    logic       hold;
    logic       dn;
    logic       bsy;
  } vec_t;

  vec_t tbl [16];
  logic [7:0] prog [9];

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 8'hFF;
      ram_b[i] = 8'hFF;
    end
    prog[0] = 8'h00; prog[1] = 8'h50; prog[2] = 8'h82; prog[3] = 8'h54; prog[4] = 8'h83;
    prog[5] = 8'h14; prog[6] = 8'h61; prog[7] = 8'h82; prog[8] = 8'h73;

    //        v     d      l     we    addr   wd     rdy   hold  dn    bsy
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 8'h50, 1'b0, 1'b1, 8'h01, 8'h50, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 8'h82, 1'b0, 1'b1, 8'h02, 8'h82, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'h54, 1'b0, 1'b1, 8'h03, 8'h54, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 8'h83, 1'b0, 1'b1, 8'h04, 8'h83, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 8'h14, 1'b0, 1'b1, 8'h05, 8'h14, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h61, 1'b0, 1'b1, 8'h06, 8'h61, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8'h82, 1'b0, 1'b1, 8'h07, 8'h82, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'h73, 1'b1, 1'b1, 8'h08, 8'h73, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

    bif_a.start = 1'b0; bif_a.base_addr = 8'h00; bif_a.in_valid = 1'b0;
    bif_a.in_data = 8'h00; bif_a.in_last = 1'b0;
    bif_b.start = 1'b0; bif_b.base_addr = 8'h00; bif_b.in_valid = 1'b0;
    bif_b.in_data = 8'h00; bif_b.in_last = 1'b0;

    // Reset values.
    tick(); tick();
    check("rst_mem_we",   32'(bif_a.mem_we),   32'd0);
    check("rst_mem_addr", 32'(bif_a.mem_addr), 32'd0);
    check("rst_in_ready", 32'(bif_a.in_ready), 32'd0);
    check("rst_cpu_hold", 32'(bif_a.cpu_hold), 32'd1);
    check("rst_busy",     32'(bif_a.busy),     32'd0);
    check("rst_done",     32'(bif_a.done),     32'd0);
    check("rst_error",    32'(bif_a.error),    32'd0);
    rst = 1'b0;
    tick();

    // No-clear instance: wraps from 0xFE, base change while busy is ignored, HOLD_CYCLES=1.
    bif_b.base_addr = 8'hFE; bif_b.start = 1'b1;
    tick();
    bif_b.start = 1'b0; bif_b.base_addr = 8'h33;
    check("b_rdy_after_start", 32'(bif_b.in_ready), 32'd1);
    check("b_no_clear_we",     32'(bif_b.mem_we),   32'd0);
    check("b_busy",            32'(bif_b.busy),     32'd1);
    bif_b.in_valid = 1'b1; bif_b.in_data = 8'hAA; tick();
    check("b_addr0", 32'(bif_b.mem_addr), 32'h0FE);
    bif_b.in_data = 8'hBB; tick();
    check("b_addr1", 32'(bif_b.mem_addr), 32'h0FF);
    bif_b.in_data = 8'hCC; bif_b.in_last = 1'b1; tick();
    check("b_addr2_wrap", 32'(bif_b.mem_addr),  32'h000);
    check("b_wdata2",     32'(bif_b.mem_wdata), 32'h0CC);
    check("b_hold_during_last", 32'(bif_b.cpu_hold), 32'd1);
    bif_b.in_valid = 1'b0; bif_b.in_last = 1'b0; tick();
    check("b_release", 32'(bif_b.cpu_hold), 32'd0);
    check("b_done",    32'(bif_b.done),     32'd1);
    check("b_wr_cnt",  32'(wr_cnt_b),       32'd3);
    check("b_ram_fe",  32'(ram_b[8'hFE]),   32'h0AA);
    check("b_ram_ff",  32'(ram_b[8'hFF]),   32'h0BB);
    check("b_ram_00",  32'(ram_b[8'h00]),   32'h0CC);

    // Clear phase with a stray start in the middle.
    bif_a.base_addr = 8'h00; bif_a.start = 1'b1;
    tick();
    bif_a.start = 1'b0;
    check("a_busy_clear", 32'(bif_a.busy), 32'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (!(bif_a.mem_we === 1'b1 && bif_a.mem_addr === 8'(i) && bif_a.mem_wdata === 8'h00 &&
            bif_a.in_ready === 1'b0 && bif_a.cpu_hold === 1'b1)) bad++;
      bif_a.start = (i == 100);
      tick();
    end
    bif_a.start = 1'b0;
    check("a_clear_seq_bad", 32'(bad), 32'd0);
    check("a_clear_end_we",  32'(bif_a.mem_we),   32'd0);
    check("a_load_rdy",      32'(bif_a.in_ready), 32'd1);
    check("a_load_hold",     32'(bif_a.cpu_hold), 32'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram_a[i] !== 8'h00) bad++;
    check("a_ram_cleared", 32'(bad), 32'd0);

    // Program image with gaps, then HOLD countdown and release.
    for (int r = 0; r < 16; r++) begin
      bif_a.in_valid = tbl[r].v; bif_a.in_data = tbl[r].d; bif_a.in_last = tbl[r].l;
      tick();
      check($sformatf("row%0d_we", r), 32'(bif_a.mem_we), 32'(tbl[r].we));
      if (tbl[r].we) begin
        check($sformatf("row%0d_addr", r),  32'(bif_a.mem_addr),  32'(tbl[r].addr));
        check($sformatf("row%0d_wdata", r), 32'(bif_a.mem_wdata), 32'(tbl[r].wd));
      end
      check($sformatf("row%0d_rdy", r),  32'(bif_a.in_ready), 32'(tbl[r].rdy));
      check($sformatf("row%0d_hold", r), 32'(bif_a.cpu_hold), 32'(tbl[r].hold));
      check($sformatf("row%0d_done", r), 32'(bif_a.done),     32'(tbl[r].dn));
      check($sformatf("row%0d_busy", r), 32'(bif_a.busy),     32'(tbl[r].bsy));
    end
    bif_a.in_valid = 1'b0; bif_a.in_last = 1'b0;
    bad = 0;
    for (int i = 0; i < 9; i++) if (ram_a[i] !== prog[i]) bad++;
    check("a_prog_image", 32'(bad), 32'd0);
    check("a_ram_after_image", 32'(ram_a[9]), 32'h000);

    // Reset in the middle of LOAD, after 5 words.
    bif_a.base_addr = 8'h10; bif_a.start = 1'b1;
    tick();
    bif_a.start = 1'b0;
    check("a_restart_hold", 32'(bif_a.cpu_hold), 32'd1);
    check("a_restart_done", 32'(bif_a.done),     32'd0);
    for (int i = 0; i < 256; i++) tick();
    for (int k = 0; k < 5; k++) begin
      bif_a.in_valid = 1'b1; bif_a.in_data = 8'(8'hC0 + k);
      tick();
    end
    bif_a.in_valid = 1'b0;
    check("a_pre_rst_we", 32'(bif_a.mem_we), 32'd1);
    rst = 1'b1;
    #2;
    check("a_midrst_we",   32'(bif_a.mem_we),   32'd0);
    check("a_midrst_hold", 32'(bif_a.cpu_hold), 32'd1);
    check("a_midrst_busy", 32'(bif_a.busy),     32'd0);
    check("a_midrst_rdy",  32'(bif_a.in_ready), 32'd0);
    check("a_ram_13",      32'(ram_a[8'h13]),   32'h0C3);
    tick();
    rst = 1'b0;
    tick();
    check("a_idle_after_rst", 32'(bif_a.busy), 32'd0);

    // Restart from CLEAR, then overflow with 256 words and no in_last.
    bif_a.base_addr = 8'h00; bif_a.start = 1'b1;
    tick();
    bif_a.start = 1'b0;
    check("a_reclear_we",   32'(bif_a.mem_we),   32'd1);
    check("a_reclear_addr", 32'(bif_a.mem_addr), 32'd0);
    for (int i = 0; i < 256; i++) tick();
    check("a_reload_rdy", 32'(bif_a.in_ready), 32'd1);
    for (int k = 0; k < 256; k++) begin
      bif_a.in_valid = 1'b1; bif_a.in_data = 8'(k);
      tick();
      if (k == 254) check("a_no_err_at_255", 32'(bif_a.error), 32'd0);
    end
    bif_a.in_valid = 1'b0;
    check("a_ovf_addr",  32'(bif_a.mem_addr),  32'h0FF);
    check("a_ovf_wdata", 32'(bif_a.mem_wdata), 32'h0FF);
    check("a_ovf_error", 32'(bif_a.error),     32'd1);
    check("a_ovf_done",  32'(bif_a.done),      32'd0);
    check("a_ovf_hold",  32'(bif_a.cpu_hold),  32'd1);
    check("a_ovf_busy",  32'(bif_a.busy),      32'd0);
    check("a_ovf_rdy",   32'(bif_a.in_ready),  32'd0);
    tick();
    check("a_ovf_sticky", 32'(bif_a.error), 32'd1);
    bif_a.start = 1'b1;
    tick();
    bif_a.start = 1'b0;
    check("a_reboot_err_clr", 32'(bif_a.error),    32'd0);
    check("a_reboot_busy",    32'(bif_a.busy),     32'd1);
    check("a_reboot_we",      32'(bif_a.mem_we),   32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
